// File: rtl/via_bus_sched.sv
// via_bus_sched: shares the 6522 VIA register port between the CPU and a
// debug/loader port, one access per clk_en slot, after writing a fixed boot
// configuration into the VIA.
module via_bus_sched #(
    parameter bit         INIT_EN      = 1'b1,
    parameter logic [7:0] INIT_DDRA    = 8'h00,
    parameter logic [7:0] INIT_DDRB    = 8'h00,
    parameter logic [7:0] INIT_PCR     = 8'h00,
    parameter logic [7:0] INIT_ACR     = 8'h00,
    parameter int         DBG_MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       cpu_sel,
    input  logic       cpu_RnW,
    input  logic [3:0] cpu_RS,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_done,
    input  logic       dbg_req,
    input  logic       dbg_RnW,
    input  logic [3:0] dbg_RS,
    input  logic [7:0] dbg_wdata,
    output logic [7:0] dbg_rdata,
    output logic       dbg_ack,
    output logic       via_CS1,
    output logic       via_nCS2,
    output logic       via_RnW,
    output logic [3:0] via_RS,
    output logic [7:0] via_wdata,
    output logic       via_data_oe,
    input  logic [7:0] via_rdata,
    output logic       init_done
);

    localparam logic [3:0] MAX_WAIT  = 4'(DBG_MAX_WAIT);
    localparam logic [2:0] INIT_LAST = 3'd6;

    typedef enum logic { ST_INIT, ST_RUN } state_t;
    typedef enum logic [1:0] { OWN_IDLE, OWN_CPU, OWN_DBG, OWN_INIT } owner_t;

    state_t     state, state_nx;
    owner_t     owner, owner_nx;
    logic [2:0] init_idx, init_idx_nx;
    logic [3:0] wait_cnt, wait_nx;
    logic       cs_nx, rnw_nx;
    logic [3:0] rs_nx;
    logic [7:0] wd_nx;
    logic [7:0] cpu_rdata_nx, dbg_rdata_nx;
    logic       cpu_done_nx, dbg_ack_nx, init_done_nx;
    logic       cpu_ok, dbg_ok, arb, grant_cpu, grant_dbg;
    logic [3:0] init_rs;
    logic [7:0] init_val;

    // boot write table: interrupts off, flags cleared, then port/control setup
    always_comb begin
        init_rs  = 4'hE;
        init_val = 8'h7F;
        case (init_idx)
            3'd0:    begin init_rs = 4'hE; init_val = 8'h7F;     end
            3'd1:    begin init_rs = 4'hD; init_val = 8'h7F;     end
            3'd2:    begin init_rs = 4'h3; init_val = INIT_DDRA; end
            3'd3:    begin init_rs = 4'h2; init_val = INIT_DDRB; end
            3'd4:    begin init_rs = 4'hC; init_val = INIT_PCR;  end
            3'd5:    begin init_rs = 4'hB; init_val = INIT_ACR;  end
            default: begin init_rs = 4'hE; init_val = 8'h7F;     end
        endcase
    end

    // slot-boundary logic: completion of the ending slot and choice of the next owner
    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        init_idx_nx  = init_idx;
        wait_nx      = wait_cnt;
        cs_nx        = via_CS1;
        rnw_nx       = via_RnW;
        rs_nx        = via_RS;
        wd_nx        = via_wdata;
        cpu_rdata_nx = cpu_rdata;
        dbg_rdata_nx = dbg_rdata;
        cpu_done_nx  = 1'b0;
        dbg_ack_nx   = 1'b0;
        init_done_nx = init_done;
        arb          = 1'b0;
        grant_cpu    = 1'b0;
        grant_dbg    = 1'b0;
        // CPU is blocked on the boundary that completes it and while its done is
        // still visible, so a requester that has not yet dropped cpu_sel is not re-served
        cpu_ok       = cpu_sel && (owner != OWN_CPU) && !cpu_done;
        // one non-debug slot always separates two debug slots
        dbg_ok       = dbg_req && (owner != OWN_DBG);

        if (clk_en) begin
            if (owner == OWN_CPU) begin
                cpu_done_nx = 1'b1;
                if (via_RnW) cpu_rdata_nx = via_rdata;
            end
            if (owner == OWN_DBG) begin
                dbg_ack_nx = 1'b1;
                if (via_RnW) dbg_rdata_nx = via_rdata;
            end

            case (state)
                ST_INIT: begin
                    if (init_idx == INIT_LAST) begin
                        state_nx     = ST_RUN;
                        init_done_nx = 1'b1;
                        arb          = 1'b1;
                    end else begin
                        owner_nx    = OWN_INIT;
                        cs_nx       = 1'b1;
                        rnw_nx      = 1'b0;
                        rs_nx       = init_rs;
                        wd_nx       = init_val;
                        init_idx_nx = init_idx + 3'd1;
                    end
                end
                default: arb = 1'b1;
            endcase

            if (arb) begin
                if (dbg_ok && wait_cnt == MAX_WAIT) grant_dbg = 1'b1;
                else if (cpu_ok)                    grant_cpu = 1'b1;
                else if (dbg_ok)                    grant_dbg = 1'b1;

                if (grant_dbg) begin
                    owner_nx = OWN_DBG;
                    cs_nx    = 1'b1;
                    rnw_nx   = dbg_RnW;
                    rs_nx    = dbg_RS;
                    wd_nx    = dbg_wdata;
                end else if (grant_cpu) begin
                    owner_nx = OWN_CPU;
                    cs_nx    = 1'b1;
                    rnw_nx   = cpu_RnW;
                    rs_nx    = cpu_RS;
                    wd_nx    = cpu_wdata;
                end else begin
                    owner_nx = OWN_IDLE;
                    cs_nx    = 1'b0;
                    rnw_nx   = 1'b1;
                end
            end

            // saturate at the override threshold so the equality test cannot be skipped
            if (dbg_req && !grant_dbg)
                wait_nx = (wait_cnt == MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1;
            else
                wait_nx = 4'd0;
        end
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state       <= INIT_EN ? ST_INIT : ST_RUN;
            owner       <= OWN_IDLE;
            init_idx    <= 3'd0;
            wait_cnt    <= 4'd0;
            via_CS1     <= 1'b0;
            via_nCS2    <= 1'b1;
            via_RnW     <= 1'b1;
            via_RS      <= 4'h0;
            via_wdata   <= 8'h00;
            via_data_oe <= 1'b0;
            cpu_rdata   <= 8'h00;
            dbg_rdata   <= 8'h00;
            cpu_done    <= 1'b0;
            dbg_ack     <= 1'b0;
            init_done   <= !INIT_EN;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            init_idx    <= init_idx_nx;
            wait_cnt    <= wait_nx;
            via_CS1     <= cs_nx;
            via_nCS2    <= !cs_nx;
            via_RnW     <= rnw_nx;
            via_RS      <= rs_nx;
            via_wdata   <= wd_nx;
            via_data_oe <= cs_nx && !rnw_nx;
            cpu_rdata   <= cpu_rdata_nx;
            dbg_rdata   <= dbg_rdata_nx;
            cpu_done    <= cpu_done_nx;
            dbg_ack     <= dbg_ack_nx;
            init_done   <= init_done_nx;
        end
    end

endmodule

// File: tb/tb_via_bus_sched.sv
// tb_via_bus_sched: directed stimulus with a scoreboard queue of expected
// VIA chip-select slots; a monitor pops and checks every granted slot and its
// completion pulse.
module tb_via_bus_sched;

    localparam logic [1:0] O_CPU = 2'd1, O_DBG = 2'd2, O_INI = 2'd3;

    typedef struct {
        logic [1:0] own;
        logic       rnw;
        logic [3:0] rs;
        logic [7:0] wd;
        logic [7:0] rd;
    } exp_t;

    logic       clk = 1'b0, nRESET = 1'b0, clk_en = 1'b0;
    logic       cpu_sel = 1'b0, cpu_RnW = 1'b1;
    logic [3:0] cpu_RS = 4'h0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_done;
    logic       dbg_req = 1'b0, dbg_RnW = 1'b1;
    logic [3:0] dbg_RS = 4'h0;
    logic [7:0] dbg_wdata = 8'h00;
    logic [7:0] dbg_rdata;
    logic       dbg_ack;
    logic       via_CS1, via_nCS2, via_RnW, via_data_oe, init_done;
    logic [3:0] via_RS;
    logic [7:0] via_wdata;
    logic [7:0] via_rdata = 8'h00;

    int   tests = 0, fails = 0, ack_cnt = 0, en_cnt = 0;
    exp_t q[$];

    via_bus_sched #(
        .INIT_EN(1'b1), .INIT_DDRA(8'h00), .INIT_DDRB(8'h0F),
        .INIT_PCR(8'h0C), .INIT_ACR(8'h00), .DBG_MAX_WAIT(3)
    ) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en),
        .cpu_sel(cpu_sel), .cpu_RnW(cpu_RnW), .cpu_RS(cpu_RS), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_RnW(dbg_RnW), .dbg_RS(dbg_RS), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .via_CS1(via_CS1), .via_nCS2(via_nCS2), .via_RnW(via_RnW), .via_RS(via_RS),
        .via_wdata(via_wdata), .via_data_oe(via_data_oe), .via_rdata(via_rdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // one slot every 4 clocks
    initial begin
        forever begin
            @(negedge clk);
            en_cnt = en_cnt + 1;
            clk_en = (en_cnt % 4 == 0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [1:0] own, input logic rnw, input logic [3:0] rs,
                                 input logic [7:0] wd, input logic [7:0] rd);
        exp_t e;
        e.own = own; e.rnw = rnw; e.rs = rs; e.wd = wd; e.rd = rd;
        q.push_back(e);
    endfunction

    function automatic void push_init();
        push(O_INI, 1'b0, 4'hE, 8'h7F, 8'h00);
        push(O_INI, 1'b0, 4'hD, 8'h7F, 8'h00);
        push(O_INI, 1'b0, 4'h3, 8'h00, 8'h00);
        push(O_INI, 1'b0, 4'h2, 8'h0F, 8'h00);
        push(O_INI, 1'b0, 4'hC, 8'h0C, 8'h00);
        push(O_INI, 1'b0, 4'hB, 8'h00, 8'h00);
    endfunction

    task automatic bnd(input int n);
        repeat (n) begin
            do @(posedge clk); while (!clk_en);
        end
        #2;
    endtask

    task automatic wait_cpu_done();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!cpu_done && n < 200);
        chk("cpu_done_seen", cpu_done, 1'b1);
    endtask

    task automatic wait_dbg_ack();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!dbg_ack && n < 200);
        chk("dbg_ack_seen", dbg_ack, 1'b1);
    endtask

    task automatic cpu_acc(input logic rnw, input logic [3:0] rs, input logic [7:0] wd);
        cpu_RnW = rnw; cpu_RS = rs; cpu_wdata = wd; cpu_sel = 1'b1;
        wait_cpu_done();
    endtask

    task automatic dbg_acc(input logic rnw, input logic [3:0] rs, input logic [7:0] wd);
        dbg_RnW = rnw; dbg_RS = rs; dbg_wdata = wd; dbg_req = 1'b1;
        wait_dbg_ack();
    endtask

    // monitor: reset values, completion pulses, and every chip-select slot against the queue
    initial begin
        logic       b, r;
        logic [1:0] last_own;
        logic       last_rnw;
        logic [7:0] last_rd;
        exp_t       it;
        last_own = 2'd0; last_rnw = 1'b1; last_rd = 8'h00;
        forever begin
            @(posedge clk);
            b = clk_en; r = nRESET;
            #1;
            if (dbg_ack) ack_cnt++;
            if (!r) begin
                chk("rst_cs1", via_CS1, 1'b0);
                chk("rst_ncs2", via_nCS2, 1'b1);
                chk("rst_rnw", via_RnW, 1'b1);
                chk("rst_rs", via_RS, 4'h0);
                chk("rst_wdata", via_wdata, 8'h00);
                chk("rst_oe", via_data_oe, 1'b0);
                chk("rst_cpu_done", cpu_done, 1'b0);
                chk("rst_dbg_ack", dbg_ack, 1'b0);
                chk("rst_cpu_rdata", cpu_rdata, 8'h00);
                chk("rst_dbg_rdata", dbg_rdata, 8'h00);
                chk("rst_init_done", init_done, 1'b0);
                last_own = 2'd0;
            end else begin
                chk("cpu_done_pulse", cpu_done, b && last_own == O_CPU);
                chk("dbg_ack_pulse", dbg_ack, b && last_own == O_DBG);
                if (b && last_own == O_CPU && last_rnw) chk("cpu_rdata", cpu_rdata, last_rd);
                if (b && last_own == O_DBG && last_rnw) chk("dbg_rdata", dbg_rdata, last_rd);
                if (b) begin
                    last_own = 2'd0;
                    if (via_CS1) begin
                        chk("slot_expected", q.size() != 0, 1'b1);
                        if (q.size() != 0) begin
                            it = q.pop_front();
                            chk("slot_rnw", via_RnW, it.rnw);
                            chk("slot_rs", via_RS, it.rs);
                            if (!it.rnw) chk("slot_wdata", via_wdata, it.wd);
                            last_own = it.own; last_rnw = it.rnw; last_rd = it.rd;
                        end
                    end
                end
                chk("ncs2_inv", via_nCS2, !via_CS1);
                chk("data_oe", via_data_oe, via_CS1 && !via_RnW);
            end
        end
    end

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #2;

        // boot sequence with a CPU write pending throughout
        push_init();
        push(O_CPU, 1'b0, 4'h1, 8'h33, 8'h00);
        cpu_RnW = 1'b0; cpu_RS = 4'h1; cpu_wdata = 8'h33; cpu_sel = 1'b1;
        nRESET = 1'b1;
        bnd(6);
        chk("init_busy", init_done, 1'b0);
        bnd(1);
        chk("init_done", init_done, 1'b1);
        wait_cpu_done();
        cpu_sel = 1'b0;
        bnd(2);

        // single CPU read
        via_rdata = 8'hA5;
        push(O_CPU, 1'b1, 4'h3, 8'h00, 8'hA5);
        cpu_acc(1'b1, 4'h3, 8'h00);
        chk("cpu_read_a5", cpu_rdata, 8'hA5);
        cpu_sel = 1'b0;
        @(posedge clk); #1;
        chk("cpu_done_1clk", cpu_done, 1'b0);
        bnd(1);

        // CPU continuous with debug contending: strict alternation
        push(O_CPU, 1'b0, 4'h0, 8'h5A, 8'h00);
        push(O_DBG, 1'b0, 4'h1, 8'h77, 8'h00);
        push(O_CPU, 1'b0, 4'h0, 8'h5B, 8'h00);
        push(O_DBG, 1'b0, 4'h1, 8'h78, 8'h00);
        push(O_CPU, 1'b1, 4'h4, 8'h00, 8'h3C);
        push(O_CPU, 1'b0, 4'h0, 8'h5D, 8'h00);
        fork
            begin
                cpu_acc(1'b0, 4'h0, 8'h5A);
                cpu_acc(1'b0, 4'h0, 8'h5B);
                via_rdata = 8'h3C;
                cpu_acc(1'b1, 4'h4, 8'h00);
                cpu_acc(1'b0, 4'h0, 8'h5D);
                cpu_sel = 1'b0;
            end
            begin
                dbg_acc(1'b0, 4'h1, 8'h77);
                dbg_acc(1'b0, 4'h1, 8'h78);
                dbg_req = 1'b0;
            end
        join
        bnd(1);

        // back-to-back debug writes: debug, idle, debug
        a0 = ack_cnt;
        push(O_DBG, 1'b0, 4'h1, 8'h11, 8'h00);
        push(O_DBG, 1'b0, 4'h1, 8'h22, 8'h00);
        dbg_acc(1'b0, 4'h1, 8'h11);
        chk("dbg_gap_idle", via_CS1, 1'b0);
        dbg_acc(1'b0, 4'h1, 8'h22);
        dbg_req = 1'b0;
        bnd(2);
        chk("dbg_ack_count", ack_cnt - a0, 2);

        // debug request withdrawn before it is granted
        a0 = ack_cnt;
        push(O_CPU, 1'b0, 4'h0, 8'h99, 8'h00);
        cpu_RnW = 1'b0; cpu_RS = 4'h0; cpu_wdata = 8'h99; cpu_sel = 1'b1;
        dbg_RnW = 1'b0; dbg_RS = 4'h1; dbg_wdata = 8'hEE; dbg_req = 1'b1;
        bnd(1);
        dbg_req = 1'b0;
        wait_cpu_done();
        cpu_sel = 1'b0;
        bnd(3);
        chk("cancel_no_ack", ack_cnt - a0, 0);

        // reset in the middle of a granted CPU write
        push(O_CPU, 1'b0, 4'h5, 8'h44, 8'h00);
        cpu_RnW = 1'b0; cpu_RS = 4'h5; cpu_wdata = 8'h44; cpu_sel = 1'b1;
        begin
            int n = 0;
            do begin @(posedge clk); #1; n++; end while (!via_CS1 && n < 200);
        end
        chk("rst_slot_granted", via_CS1, 1'b1);
        #3;
        nRESET = 1'b0; cpu_sel = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_cs_drop", via_CS1, 1'b0);
        repeat (2) @(posedge clk);
        #2;

        // reboot with both requesters waiting: debug overrides at the first RUN slot
        push_init();
        push(O_DBG, 1'b0, 4'h1, 8'hAB, 8'h00);
        push(O_CPU, 1'b1, 4'h4, 8'h00, 8'h5E);
        via_rdata = 8'h5E;
        cpu_RnW = 1'b1; cpu_RS = 4'h4; cpu_wdata = 8'h00; cpu_sel = 1'b1;
        dbg_RnW = 1'b0; dbg_RS = 4'h1; dbg_wdata = 8'hAB; dbg_req = 1'b1;
        nRESET = 1'b1;
        fork
            begin wait_dbg_ack(); dbg_req = 1'b0; end
            begin wait_cpu_done(); cpu_sel = 1'b0; end
        join
        chk("reboot_cpu_rdata", cpu_rdata, 8'h5E);
        bnd(3);
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
